// File: rtl/line_memory_if.sv
// Request/response bundle between a line requester and line_memory_responder.
interface line_memory_if #(
   parameter int BLOCK_SIZE = 16
);
   logic                      is_input_valid;
   logic [31:0]               addr;
   logic                      mem_read;
   logic                      mem_write;
   logic [BLOCK_SIZE*8-1:0]   din;
   logic                      is_output_valid;
   logic [BLOCK_SIZE*8-1:0]   dout;
   logic                      mem_ready;
   logic [31:0]               read_count;
   logic [31:0]               write_count;

   modport master (
      output is_input_valid, addr, mem_read, mem_write, din,
      input  is_output_valid, dout, mem_ready, read_count, write_count
   );

   modport slave (
      input  is_input_valid, addr, mem_read, mem_write, din,
      output is_output_valid, dout, mem_ready, read_count, write_count
   );
endinterface

// File: rtl/line_memory_responder.sv
// Line-granular memory with a fixed MEM_DELAY access latency and one request in flight.
// Requests arriving while BUSY are dropped, never queued; storage survives reset.
module line_memory_responder #(
   parameter int BLOCK_SIZE = 16,
   parameter int NUM_LINES  = 256,
   parameter int MEM_DELAY  = 50
) (
   input  logic         clk,
   input  logic         reset,
   line_memory_if.slave bus
);
   localparam int LINE_W = BLOCK_SIZE * 8;
   localparam int IDX_W  = $clog2(NUM_LINES);
   localparam int CNT_W  = $clog2(MEM_DELAY) + 1;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   typedef struct packed {
      logic              wr;
      logic [IDX_W-1:0]  idx;
      logic [LINE_W-1:0] data;
   } req_t;

   state_t            state, state_nx;
   req_t              req;
   logic [CNT_W-1:0]  cnt;
   logic              accept, complete;
   logic [LINE_W-1:0] storage [NUM_LINES];
   logic [LINE_W-1:0] dout;
   logic              out_vld;
   logic [31:0]       read_count, write_count;
   logic              unused_addr_hi;

   // Upper address bits are deliberately dropped: indices wrap modulo NUM_LINES.
   assign unused_addr_hi      = ^bus.addr[31:IDX_W];

   assign bus.mem_ready       = (state != BUSY);
   assign bus.is_output_valid = out_vld;
   assign bus.dout            = dout;
   assign bus.read_count      = read_count;
   assign bus.write_count     = write_count;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      accept   = 1'b0;
      complete = 1'b0;
      case (state)
         IDLE, DONE: begin
            accept   = bus.is_input_valid && (bus.mem_read ^ bus.mem_write);
            state_nx = accept ? BUSY : IDLE;
         end
         BUSY: begin
            if (cnt == '0) begin
               complete = 1'b1;
               state_nx = DONE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         req         <= '0;
         cnt         <= '0;
         dout        <= '0;
         out_vld     <= 1'b0;
         read_count  <= '0;
         write_count <= '0;
      end else begin
         out_vld <= 1'b0;
         if (accept) begin
            req <= '{wr: bus.mem_write, idx: bus.addr[IDX_W-1:0], data: bus.din};
            cnt <= CNT_W'(MEM_DELAY - 1);
         end else if (state == BUSY && cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
         end
         if (complete) begin
            if (req.wr) begin
               write_count <= write_count + 32'd1;
            end else begin
               dout       <= storage[req.idx];
               out_vld    <= 1'b1;
               read_count <= read_count + 32'd1;
            end
         end
      end
   end

   // No reset here: an aborted write never reaches this edge because reset forces IDLE.
   always_ff @(posedge clk) begin
      if (complete && req.wr) storage[req.idx] <= req.data;
   end
endmodule

// File: tb/tb_line_memory_responder.sv
// Bench for line_memory_responder: vector table, hand-written corner sequences and
// random traffic, all checked against a transaction-timeline reference model.
module tb_line_memory_responder;
   localparam int D  = 4;
   localparam int BS = 16;
   localparam int NL = 256;
   localparam int W  = BS * 8;

   localparam logic [W-1:0] DAT_A   = 128'h0123456789ABCDEF0123456789ABCDEF;
   localparam logic [W-1:0] DAT_B   = 128'hB0B1B2B3B4B5B6B7B8B9BABBBCBDBEBF;
   localparam logic [W-1:0] DAT_C   = 128'hC3C3C3C35A5A5A5AC3C3C3C35A5A5A5A;
   localparam logic [W-1:0] DAT_OLD = 128'h10101010202020203030303040404040;
   localparam logic [W-1:0] DAT_AA  = {16{8'hAA}};
   localparam logic [W-1:0] DAT_E   = 128'hE0E1E2E3E4E5E6E7E8E9EAEBECEDEEEF;

   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   line_memory_if #(.BLOCK_SIZE(BS)) b ();

   line_memory_responder #(.BLOCK_SIZE(BS), .NUM_LINES(NL), .MEM_DELAY(D)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (b)
   );

   int checks = 0;
   int errors = 0;

   // Reference model: a pending transaction finishes exactly D edges after it was accepted.
   logic [W-1:0] ref_mem [NL];
   bit           known   [NL];
   bit           pend;
   bit           p_wr;
   int           p_idx;
   logic [W-1:0] p_din;
   longint       edge_n = 0;
   longint       done_at;
   bit           m_valid;
   logic [W-1:0] m_dout;
   bit           m_dout_known;
   logic [31:0]  m_rc, m_wc;

   typedef struct {
      bit           rd;
      bit           wr;
      logic [31:0]  addr;
      logic [W-1:0] din;
      bit           exp_acc;
      bit           exp_valid;
      logic [W-1:0] exp_dout;
   } vec_t;

   vec_t vec [10];

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic drive(input bit v, input bit rd, input bit wr, input logic [31:0] a,
                        input logic [W-1:0] d);
      b.is_input_valid = v;
      b.mem_read       = rd;
      b.mem_write      = wr;
      b.addr           = a;
      b.din            = d;
   endtask

   task automatic idle();
      drive(1'b0, 1'b0, 1'b0, 32'h0, '0);
   endtask

   function automatic logic [W-1:0] rnd_line();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // Reset is checked against its fixed values before any clock edge arrives.
   task automatic do_reset();
      reset = 1'b1;
      #1;
      chk("rst_ready", W'(b.mem_ready), W'(1));
      chk("rst_valid", W'(b.is_output_valid), '0);
      chk("rst_dout", b.dout, '0);
      chk("rst_rc", W'(b.read_count), '0);
      chk("rst_wc", W'(b.write_count), '0);
      pend = 0; m_valid = 0; m_dout = '0; m_dout_known = 1; m_rc = '0; m_wc = '0;
      @(posedge clk);
      #1 reset = 1'b0;
   endtask

   // Advance one edge: update the model from the inputs now applied, then compare.
   task automatic step();
      bit legal;
      legal   = b.is_input_valid && (b.mem_read != b.mem_write);
      m_valid = 0;
      if (pend && edge_n == done_at) begin
         pend = 0;
         if (p_wr) begin
            ref_mem[p_idx] = p_din;
            known[p_idx]   = 1;
            m_wc++;
         end else begin
            m_valid      = 1;
            m_dout       = ref_mem[p_idx];
            m_dout_known = known[p_idx];
            m_rc++;
         end
      end else if (!pend && legal) begin
         pend    = 1;
         done_at = edge_n + D;
         p_wr    = b.mem_write;
         p_idx   = int'(b.addr % NL);
         p_din   = b.din;
      end
      edge_n++;
      @(posedge clk);
      #1;
      chk("ready", W'(b.mem_ready), W'(!pend));
      chk("valid", W'(b.is_output_valid), W'(m_valid));
      chk("read_count", W'(b.read_count), W'(m_rc));
      chk("write_count", W'(b.write_count), W'(m_wc));
      if (m_dout_known) chk("dout", b.dout, m_dout);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      int p1, p2, npulse;
      vec[0] = '{0, 1, 32'h0000_0005, DAT_A,   1, 0, '0};
      vec[1] = '{1, 0, 32'h0000_0005, '0,      1, 1, DAT_A};
      vec[2] = '{0, 1, 32'h0000_0105, DAT_B,   1, 0, '0};
      vec[3] = '{1, 0, 32'h0000_0005, '0,      1, 1, DAT_B};
      vec[4] = '{1, 1, 32'h0000_0007, DAT_C,   0, 0, '0};
      vec[5] = '{0, 0, 32'h0000_0007, DAT_C,   0, 0, '0};
      vec[6] = '{0, 1, 32'h0000_03FF, DAT_C,   1, 0, '0};
      vec[7] = '{1, 0, 32'h0000_00FF, '0,      1, 1, DAT_C};
      vec[8] = '{1, 0, 32'hFFFF_FF05, '0,      1, 1, DAT_B};
      vec[9] = '{0, 1, 32'h0000_0010, DAT_OLD, 1, 0, '0};

      idle();
      #1;
      do_reset();

      // Illegal requests (both ops) are ignored entirely.
      drive(1'b1, 1'b1, 1'b1, 32'h5, DAT_C);
      repeat (3) begin
         step();
         chk("illegal_ready", W'(b.mem_ready), W'(1));
         chk("illegal_rc", W'(b.read_count), '0);
         chk("illegal_wc", W'(b.write_count), '0);
         chk("illegal_valid", W'(b.is_output_valid), '0);
      end
      idle();

      for (int i = 0; i < 10; i++) begin
         drive(1'b1, vec[i].rd, vec[i].wr, vec[i].addr, vec[i].din);
         step();
         chk("tbl_accept", W'(b.mem_ready), W'(!vec[i].exp_acc));
         idle();
         if (vec[i].exp_acc) begin
            for (int k = 1; k < D; k++) begin
               step();
               chk("tbl_busy_ready", W'(b.mem_ready), '0);
               chk("tbl_busy_valid", W'(b.is_output_valid), '0);
            end
            step();
            chk("tbl_done_ready", W'(b.mem_ready), W'(1));
            chk("tbl_done_valid", W'(b.is_output_valid), W'(vec[i].exp_valid));
            if (vec[i].exp_valid) chk("tbl_dout", b.dout, vec[i].exp_dout);
            if (i == 1) begin
               chk("first_rd_rc", W'(b.read_count), W'(1));
               chk("first_rd_wc", W'(b.write_count), W'(1));
            end
         end
         step();
      end
      chk("tbl_total_rc", W'(b.read_count), W'(4));
      chk("tbl_total_wc", W'(b.write_count), W'(4));

      // Reset two cycles into a write: write aborted, old line survives.
      drive(1'b1, 1'b0, 1'b1, 32'h10, DAT_AA);
      step();
      idle();
      step();
      step();
      #2;
      do_reset();
      drive(1'b1, 1'b1, 1'b0, 32'h10, '0);
      step();
      chk("post_rst_accept", W'(b.mem_ready), '0);
      idle();
      repeat (D) step();
      chk("abort_valid", W'(b.is_output_valid), W'(1));
      chk("abort_dout", b.dout, DAT_OLD);
      chk("abort_wc", W'(b.write_count), '0);
      step();

      // Held read request: accepted again in the DONE cycle, so completions are
      // D+1 edges apart (D idle cycles between the two pulses).
      drive(1'b1, 1'b1, 1'b0, 32'h5, '0);
      npulse = 0; p1 = -1; p2 = -1;
      for (int s = 0; s < 2 * D + 2; s++) begin
         step();
         if (b.is_output_valid) begin
            npulse++;
            if (p1 < 0) p1 = s; else p2 = s;
         end
      end
      idle();
      chk("b2b_pulses", W'(npulse), W'(2));
      chk("b2b_gap", W'(p2 - p1), W'(D + 1));
      step();

      // Inputs churn during BUSY; the latched write must be what lands.
      drive(1'b1, 1'b0, 1'b1, 32'h20, DAT_E);
      step();
      for (int k = 0; k < D; k++) begin
         drive(1'b1, 1'b0, 1'b1, $urandom, rnd_line());
         step();
      end
      idle();
      step();
      drive(1'b1, 1'b1, 1'b0, 32'h20, '0);
      step();
      idle();
      repeat (D) step();
      chk("latch_valid", W'(b.is_output_valid), W'(1));
      chk("latch_dout", b.dout, DAT_E);
      step();

      for (int n = 0; n < 400; n++) begin
         logic [31:0] a;
         int          op;
         bit          rd, wr;
         case ($urandom_range(0, 5))
            0:       a = 32'h5;
            1:       a = 32'h105;
            2:       a = 32'h10;
            3:       a = 32'h20;
            4:       a = {$urandom_range(0, 15), 8'h33};
            default: a = $urandom;
         endcase
         op = $urandom_range(0, 9);
         rd = (op < 4) || (op == 8);
         wr = (op >= 4 && op < 9);
         drive($urandom_range(0, 3) != 0, rd, wr, a, rnd_line());
         step();
         if ($urandom_range(0, 99) == 0) begin
            #2;
            do_reset();
         end
      end
      idle();
      repeat (D + 2) step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
